// File: rtl/lsm_pkg.sv
// Shared definitions for the LDM/STM sequencer: state encoding, IR field
// positions, beat size and the start-offset rule for the four address modes.
package lsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } lsm_state_e;

    localparam int         LIST_W     = 16;
    localparam int         IR_L_BIT   = 20;
    localparam int         IR_W_BIT   = 21;
    localparam int         IR_U_BIT   = 23;
    localparam int         IR_P_BIT   = 24;
    localparam logic [7:0] BEAT_BYTES = 8'd4;

    function automatic logic [7:0] beat_span(input logic [4:0] cnt);
        return BEAT_BYTES * {3'b000, cnt};
    endfunction

    // IA: 0, IB: +4, DA: -4n+4, DB: -4n (8-bit two's complement)
    function automatic logic [7:0] start_offset(input logic u, input logic p,
                                                input logic [4:0] n);
        logic [7:0] off;
        case ({u, p})
            2'b10:   off = 8'd0;
            2'b11:   off = BEAT_BYTES;
            2'b00:   off = BEAT_BYTES - beat_span(n);
            default: off = 8'd0 - beat_span(n);
        endcase
        return off;
    endfunction

endpackage

// File: rtl/lsm_prio_enc.sv
// 16-bit lowest-set-bit encoder: idx_o is the index of the lowest 1 in vec_i,
// valid_o flags a non-empty vector (idx_o is 0 when empty).
module lsm_prio_enc (
    input  logic [15:0] vec_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    always_comb begin
        idx_o   = 4'd0;
        valid_o = |vec_i;
        for (int i = 15; i >= 0; i--) begin
            if (vec_i[i]) idx_o = 4'(i);
        end
    end

endmodule

// File: rtl/lsm_sequencer.sv
// LDM/STM beat sequencer: walks the captured register list lowest-first,
// issuing one memory beat per register, then an optional base write-back.
module lsm_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic [3:0]  REG_COUNTER,
    output logic        LSM_RD_MUX,
    output logic        LATCH_REG,
    output logic        WRITE_BACK,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [7:0]  addr_offset,
    output logic [7:0]  wb_offset
);
    import lsm_pkg::*;

    // state   | meaning
    // IDLE    | waiting for start; captures IR fields on start
    // XFER    | one beat per remaining list bit, held until mem_ready
    // WB      | WRITE_BACK strobe when W was set
    // DONE    | one-cycle done pulse, then back to IDLE

    lsm_state_e  state_q;
    logic [15:0] list_q;
    logic [15:0] list_d;
    logic        l_q, w_q, u_q, p_q;
    logic [4:0]  n_q;
    logic [4:0]  k_q;
    logic [7:0]  start_off_q;
    logic [4:0]  ir_cnt;
    logic [3:0]  enc_idx;
    logic        enc_valid;
    logic        in_xfer;
    logic        unused_ir;

    assign unused_ir = ^{IR[31:25], IR[22], IR[19:16]};

    lsm_prio_enc u_prio_enc (
        .vec_i   (list_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        ir_cnt = 5'd0;
        for (int i = 0; i < LIST_W; i++) begin
            ir_cnt = ir_cnt + {4'd0, IR[i]};
        end
    end

    assign list_d = enc_valid ? (list_q & ~(16'h0001 << enc_idx)) : list_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            list_q      <= '0;
            l_q         <= 1'b0;
            w_q         <= 1'b0;
            u_q         <= 1'b0;
            p_q         <= 1'b0;
            n_q         <= '0;
            k_q         <= '0;
            start_off_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        list_q      <= IR[15:0];
                        l_q         <= IR[IR_L_BIT];
                        w_q         <= IR[IR_W_BIT];
                        u_q         <= IR[IR_U_BIT];
                        p_q         <= IR[IR_P_BIT];
                        n_q         <= ir_cnt;
                        k_q         <= '0;
                        start_off_q <= start_offset(IR[IR_U_BIT], IR[IR_P_BIT], ir_cnt);
                        state_q     <= (ir_cnt != 5'd0) ? ST_XFER : ST_WB;
                    end
                end
                ST_XFER: begin
                    if (mem_ready) begin
                        list_q <= list_d;
                        k_q    <= k_q + 5'd1;
                        if (list_d == 16'd0) state_q <= ST_WB;
                    end
                end
                ST_WB:   state_q <= ST_DONE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // p_q is only needed at capture time; keep it visible for debug.
    logic unused_p;
    assign unused_p = p_q;

    assign in_xfer     = (state_q == ST_XFER);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign LSM_RD_MUX  = in_xfer;
    assign MEM_READ    = in_xfer & l_q;
    assign MEM_WRITE   = in_xfer & ~l_q;
    assign LATCH_REG   = in_xfer & l_q & mem_ready;
    assign REG_COUNTER = in_xfer ? enc_idx : 4'd0;
    assign addr_offset = in_xfer ? (start_off_q + beat_span(k_q)) : 8'd0;
    assign WRITE_BACK  = (state_q == ST_WB) & w_q;
    assign wb_offset   = u_q ? beat_span(n_q) : (8'd0 - beat_span(n_q));

endmodule

// File: tb/tb_lsm_sequencer.sv
// Bench for lsm_sequencer: directed scenarios plus randomized operations
// checked against a list-walking reference model.
module tb_lsm_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] IR = 32'd0;
    logic        mem_ready = 1'b0;
    logic        busy, done, LSM_RD_MUX, LATCH_REG, WRITE_BACK, MEM_READ, MEM_WRITE;
    logic [3:0]  REG_COUNTER;
    logic [7:0]  addr_offset, wb_offset;

    lsm_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .IR          (IR),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .done        (done),
        .REG_COUNTER (REG_COUNTER),
        .LSM_RD_MUX  (LSM_RD_MUX),
        .LATCH_REG   (LATCH_REG),
        .WRITE_BACK  (WRITE_BACK),
        .MEM_READ    (MEM_READ),
        .MEM_WRITE   (MEM_WRITE),
        .addr_offset (addr_offset),
        .wb_offset   (wb_offset)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rdmux;
        logic       latch;
        logic       wb;
        logic       mr;
        logic       mw;
        logic [3:0] rc;
        logic [7:0] addr;
    } obs_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t obs[$];
    bit   rdy_q[$];
    logic [7:0] wbo_q[$];
    bit   mr_pat[$];

    function automatic logic [31:0] mk_ir(input logic [15:0] list, input logic l,
                                          input logic w, input logic u, input logic p);
        logic [31:0] r;
        r = $urandom;
        r[15:0] = list;
        r[20] = l;
        r[21] = w;
        r[23] = u;
        r[24] = p;
        return r;
    endfunction

    // Issues start, then records one observation per cycle until done (bounded).
    task automatic drive_op(input logic [31:0] ir, input bit hold);
        obs_t o;
        obs.delete(); rdy_q.delete(); wbo_q.delete();
        @(negedge clk);
        IR = ir; start = 1'b1; mem_ready = 1'($urandom);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = hold; IR = $urandom;
            mem_ready = (mr_pat.size() > 0) ? mr_pat.pop_front() : 1'b1;
            #1;
            o = '{busy:busy, done:done, rdmux:LSM_RD_MUX, latch:LATCH_REG, wb:WRITE_BACK,
                  mr:MEM_READ, mw:MEM_WRITE, rc:REG_COUNTER, addr:addr_offset};
            obs.push_back(o); rdy_q.push_back(mem_ready); wbo_q.push_back(wb_offset);
            if (done) break;
        end
        start = 1'b0;
        mr_pat.delete();
    endtask

    function automatic logic [26:0] all_outs();
        return {busy, done, REG_COUNTER, LSM_RD_MUX, LATCH_REG, WRITE_BACK,
                MEM_READ, MEM_WRITE, addr_offset, wb_offset};
    endfunction

    task automatic test_reset;
        #1;
        n_checks++;
        if (all_outs() !== 27'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_ldmia;
        int exp_rc[3] = '{0, 1, 3};
        int nl, nw, first_done;
        drive_op(mk_ir(16'h000B, 1, 1, 1, 0), 0);
        n_checks++;
        if (obs.size() != 5) begin n_fail++; $display("FAIL ldmia_len: got %0d expected 5", obs.size()); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (k >= obs.size() || obs[k].rc != 4'(exp_rc[k]) || obs[k].addr != 8'(4*k)) begin
                n_fail++; $display("FAIL ldmia_beat%0d: got rc=%0d addr=%0d expected rc=%0d addr=%0d",
                                   k, obs[k].rc, obs[k].addr, exp_rc[k], 4*k);
            end
        end
        nl = 0; nw = 0; first_done = -1;
        foreach (obs[i]) begin
            nl += int'(obs[i].latch); nw += int'(obs[i].wb);
            if (obs[i].done && first_done < 0) first_done = i + 1;
        end
        n_checks++;
        if (nl != 3) begin n_fail++; $display("FAIL ldmia_latch_count: got %0d expected 3", nl); end
        n_checks++;
        if (nw != 1 || obs.size() < 4 || !obs[3].wb || wbo_q[3] != 8'd12) begin
            n_fail++; $display("FAIL ldmia_writeback: got count=%0d wbo=%0d expected count=1 wbo=12", nw, wbo_q[3]);
        end
        n_checks++;
        if (first_done != 5) begin n_fail++; $display("FAIL ldmia_done_latency: got %0d expected 5", first_done); end
    endtask

    task automatic test_stmdb;
        int nl, nw;
        drive_op(mk_ir(16'h4010, 0, 0, 0, 1), 0);
        n_checks++;
        if (obs.size() != 4 || obs[0].addr != 8'hF8 || obs[0].rc != 4'd4 || !obs[0].mw
            || obs[1].addr != 8'hFC || obs[1].rc != 4'd14 || !obs[1].mw) begin
            n_fail++; $display("FAIL stmdb_beats: got len=%0d b0=%h b1=%h expected len=4 addr F8,FC rc 4,14",
                               obs.size(), obs[0], obs[1]);
        end
        nl = 0; nw = 0;
        foreach (obs[i]) begin nl += int'(obs[i].latch); nw += int'(obs[i].wb); end
        n_checks++;
        if (nl != 0 || nw != 0) begin
            n_fail++; $display("FAIL stmdb_no_latch_wb: got latch=%0d wb=%0d expected 0 0", nl, nw);
        end
        n_checks++;
        if (wbo_q.size() < 3 || wbo_q[2] != 8'hF8) begin
            n_fail++; $display("FAIL stmdb_wb_offset: got %h expected F8", wbo_q[2]);
        end
    endtask

    task automatic test_ldmib_wait;
        mr_pat = '{0, 0, 0, 1};
        drive_op(mk_ir(16'h0001, 1, 0, 1, 1), 0);
        n_checks++;
        if (obs.size() != 6) begin n_fail++; $display("FAIL ldmib_len: got %0d expected 6", obs.size()); end
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (c >= obs.size() || !obs[c].mr || obs[c].rc != 4'd0 || obs[c].addr != 8'd4
                || obs[c].latch != (c == 3)) begin
                n_fail++; $display("FAIL ldmib_hold%0d: got %h expected mr=1 rc=0 addr=4 latch=%0d",
                                   c, obs[c], c == 3);
            end
        end
    endtask

    task automatic test_empty;
        int nb;
        drive_op(mk_ir(16'h0000, 1, 1, 1, 0), 0);
        nb = 0;
        foreach (obs[i]) nb += int'(obs[i].mr | obs[i].mw);
        n_checks++;
        if (nb != 0 || obs.size() != 2) begin
            n_fail++; $display("FAIL empty_no_beats: got beats=%0d len=%0d expected 0 2", nb, obs.size());
        end
        n_checks++;
        if (!obs[0].wb || wbo_q[0] != 8'd0 || !obs[1].done) begin
            n_fail++; $display("FAIL empty_wb_done: got wb=%0d wbo=%0d done=%0d expected 1 0 1",
                               obs[0].wb, wbo_q[0], obs[1].done);
        end
    endtask

    task automatic test_ldmda_full;
        int bad;
        drive_op(mk_ir(16'hFFFF, 1, 1, 0, 0), 0);
        n_checks++;
        if (obs.size() != 18) begin n_fail++; $display("FAIL ldmda_len: got %0d expected 18", obs.size()); end
        bad = 0;
        for (int k = 0; k < 16 && k < obs.size(); k++)
            if (obs[k].addr != 8'(-60 + 4*k) || obs[k].rc != 4'(k) || !obs[k].latch) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL ldmda_beats: got %0d bad beats expected 0", bad); end
        n_checks++;
        if (obs.size() < 17 || obs[15].rc != 4'd15 || obs[16].mr || wbo_q[16] != 8'hC0) begin
            n_fail++; $display("FAIL ldmda_pc_last_wb: got rc15=%0d wbo=%h expected 15 C0", obs[15].rc, wbo_q[16]);
        end
    endtask

    task automatic test_reset_mid;
        int seen_done;
        @(negedge clk);
        IR = mk_ir(16'h00F0, 1, 1, 1, 0); start = 1'b1; mem_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (!busy || !MEM_READ || REG_COUNTER != 4'd5) begin
            n_fail++; $display("FAIL rstmid_in_beat2: got busy=%0d rd=%0d rc=%0d expected 1 1 5", busy, MEM_READ, REG_COUNTER);
        end
        rst = 1'b1; #1;
        n_checks++;
        if (all_outs() !== 27'd0) begin n_fail++; $display("FAIL rstmid_immediate: got %h expected 0", all_outs()); end
        seen_done = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (all_outs() !== 27'd0) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", seen_done); end
        rst = 1'b0;
        drive_op(mk_ir(16'h0003, 1, 0, 1, 0), 0);
        n_checks++;
        if (obs.size() != 4 || obs[0].rc != 4'd0 || obs[1].rc != 4'd1 || !obs[3].done) begin
            n_fail++; $display("FAIL rstmid_restart: got len=%0d expected 4 with rc 0,1 then done", obs.size());
        end
    endtask

    // Random ops (random stalls, start sometimes held high) vs. a list-walk model.
    task automatic test_random;
        logic [15:0] list;
        logic        l, w, u, p;
        bit          hold;
        int          regs[$];
        int          n, st, k, c;
        obs_t        e;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 5))
                0:       list = 16'h0000;
                1:       list = 16'hFFFF;
                2:       list = 16'h0001 << $urandom_range(0, 15);
                default: list = 16'($urandom);
            endcase
            l = 1'($urandom); w = 1'($urandom); u = 1'($urandom); p = 1'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 40; i++) mr_pat.push_back($urandom_range(0, 9) >= 3);
            drive_op(mk_ir(list, l, w, u, p), hold);
            regs.delete();
            for (int b = 0; b < 16; b++) if (list[b]) regs.push_back(b);
            n  = regs.size();
            st = u ? (p ? 4 : 0) : (p ? -4*n : -4*n + 4);
            k = 0; c = 0;
            while (k < n && c < obs.size()) begin
                e = '{busy:1'b1, done:1'b0, rdmux:1'b1, latch:l & rdy_q[c], wb:1'b0,
                      mr:l, mw:~l, rc:4'(regs[k]), addr:8'(st + 4*k)};
                n_checks++;
                if (obs[c] !== e) begin
                    n_fail++; $display("FAIL rand%0d_beat%0d: got %h expected %h", t, k, obs[c], e);
                end
                if (rdy_q[c]) k++;
                c++;
            end
            e = '{busy:1'b1, done:1'b0, rdmux:1'b0, latch:1'b0, wb:w, mr:1'b0, mw:1'b0, rc:4'd0, addr:8'd0};
            n_checks++;
            if (c >= obs.size() || obs[c] !== e || wbo_q[c] != 8'(u ? 4*n : -4*n)) begin
                n_fail++; $display("FAIL rand%0d_wb: got %h wbo=%h expected %h wbo=%h",
                                   t, obs[c], wbo_q[c], e, 8'(u ? 4*n : -4*n));
            end
            c++;
            e = '{busy:1'b1, done:1'b1, rdmux:1'b0, latch:1'b0, wb:1'b0, mr:1'b0, mw:1'b0, rc:4'd0, addr:8'd0};
            n_checks++;
            if (obs.size() != c + 1 || obs[c] !== e) begin
                n_fail++; $display("FAIL rand%0d_done: got len=%0d last=%h expected len=%0d last=%h",
                                   t, obs.size(), obs[obs.size()-1], c + 1, e);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_ldmia;
        test_stmdb;
        test_ldmib_wait;
        test_empty;
        test_ldmda_full;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/lsm_sequencer.md
LSM_SEQUENCER -- requirements
Module: lsm_sequencer

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  request to run the LDM/STM held in IR; sampled only in IDLE.
REQ-004 IR  in  32  instruction word; bits [15:0] register list, [20] L, [21] W, [23] U, [24] P.
REQ-005 mem_ready  in  1  memory completes the current beat this cycle.
REQ-006 busy  out  1  high from the cycle after start is accepted until the DONE cycle inclusive.
REQ-007 done  out  1  one-cycle completion pulse.
REQ-008 REG_COUNTER  out  4  index of the register in the current beat.
REQ-009 LSM_RD_MUX  out  1  selects REG_COUNTER as the register-bank read/write index.
REQ-010 LATCH_REG  out  1  one-cycle register-bank write strobe for load beats.
REQ-011 WRITE_BACK  out  1  one-cycle base write-back strobe.
REQ-012 MEM_READ / MEM_WRITE  out  1 each  beat request for load or store.
REQ-013 addr_offset  out  8  signed byte offset from base for the current beat.
REQ-014 wb_offset  out  8  signed byte offset for the written-back base, +4n (U=1) or -4n (U=0).

Function
REQ-015 States: IDLE, XFER, WB, DONE. The state machine shall have no other reachable states.
REQ-016 In IDLE with start=1, the block shall capture list, L, W, U and P, and shall compute n = popcount(list), 0..16.
REQ-017 After capture, the state shall be XFER if n>0, and WB if n=0 (no beats).
REQ-018 Start shall be ignored outside IDLE.
REQ-019 The IR input shall be don't-care after capture.
REQ-020 In XFER:
- REG_COUNTER shall be the lowest set bit of the remaining list.
- LSM_RD_MUX shall be 1.
- MEM_READ shall equal L; MEM_WRITE shall equal !L.
REQ-021 A beat shall be held stable until mem_ready=1. Waiting is unbounded.
REQ-022 In the cycle mem_ready=1 during a load beat, LATCH_REG shall be 1 for exactly that cycle.
REQ-023 On mem_ready=1, the current bit shall be cleared and the beat index k shall increment.
REQ-024 The next beat shall start in the following cycle, giving a minimum of 1 cycle per beat.
REQ-025 After the last beat, the state shall become WB.
REQ-026 Starting offset by mode: IA (U=1,P=0) 0; IB (U=1,P=1) +4; DA (U=0,P=0) -4n+4; DB (U=0,P=1) -4n.
REQ-027 addr_offset shall equal the starting offset + 4k, computed in 8-bit two's complement, with no overflow for n≤16.
REQ-028 In WB, WRITE_BACK shall equal W for one cycle, and the state shall become DONE.
REQ-029 In DONE, done=1 for one cycle, then the state shall return to IDLE.
REQ-030 A new start may be accepted in the cycle after DONE.
REQ-031 Outside XFER, MEM_READ, MEM_WRITE, LATCH_REG and LSM_RD_MUX shall be 0.
REQ-032 Outside XFER, REG_COUNTER and addr_offset shall be 0.
REQ-033 Outside WB, WRITE_BACK shall be 0.
REQ-034 A list containing bit 15 (PC) shall be transferred as an ordinary register, last in order.

Reset
REQ-035 While rst=1, the state shall be IDLE and every output and captured field shall be 0.
REQ-036 Reset asserted mid-operation shall abort immediately: no further beats, no done, no WRITE_BACK.

Structure
REQ-037 A shared package lsm_pkg shall hold the state enum, the IR bit positions (L=20, W=21, U=23, P=24), and the beat size constant 4.
REQ-038 The block shall instantiate one sub-module, lsm_prio_enc: a 16-bit lowest-set-bit encoder with index and valid outputs.
REQ-039 popcount shall be computed locally.

Verification
REQ-040 LDMIA list 0x000B, W=1, mem_ready always 1:
- REG_COUNTER shall be 0, 1, 3 on consecutive cycles.
- addr_offset shall be 0, 4, 8.
- LATCH_REG shall be high for 3 cycles.
- WRITE_BACK shall pulse once with wb_offset = +12.
- done shall pulse 5 cycles after start.
REQ-041 STMDB list 0x4010 (R4, R14), W=0:
- addr_offset shall be -8, then -4.
- MEM_WRITE shall be high with LATCH_REG never high.
- WRITE_BACK shall stay 0.
- wb_offset shall be -8.
REQ-042 LDMIB list 0x0001 with mem_ready held low 3 cycles:
- MEM_READ, REG_COUNTER=0 and addr_offset=+4 shall stay stable for 4 cycles.
- LATCH_REG shall be high only in the 4th cycle.
REQ-043 Empty list 0x0000, W=1: there shall be no beats, WRITE_BACK shall pulse with wb_offset=0, and done shall pulse 2 cycles after start.
REQ-044 LDMDA list 0xFFFF:
- 16 beats, addr_offset from -60 to 0.
- R15 shall be the last beat.
- wb_offset shall be -64.
REQ-045 Reset asserted during beat 2 of a 4-register LDM: all outputs shall be 0 at once, with no done; a start after reset is released shall run normally.
